// File: rtl/uart_replay_engine_pkg.sv
// Shared types and default widths for the UART replay engine.
// Imported by the engine top and its buffer RAM.
package uart_replay_engine_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        RECV,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

endpackage

// File: rtl/ram_sw_ar.sv
// Single-write-port RAM with asynchronous read.
// Holds the received packet until it is replayed.
module ram_sw_ar
    import uart_replay_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port: lands on the edge of the strobe cycle.
    always_ff @(posedge clk) begin
        if (cs && we) begin
            mem[addr_in] <= data_in;
        end
    end

    assign data_out = (cs && oe) ? mem[addr_out] : '0;

endmodule

// File: rtl/uart_replay_engine.sv
// UART loopback command: receive a length-prefixed packet,
// buffer it, then replay the bytes through the shared transmitter.
module uart_replay_engine
    import uart_replay_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  activate,
    output logic                  done,
    input  logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start,
    input  logic                  tx_active,
    input  logic                  tx_done
);

    // Wide enough to hold pointer+1 and len without overflow.
    localparam int CW =
        ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + 1;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic                  we;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_last;
    logic                  rd_last;

    assign wr_last = (CW'(wr_q) + CW'(1)) == CW'(len_q);
    assign rd_last = (CW'(rd_q) + CW'(1)) == CW'(len_q);

    assign tx_data  = txd_q;
    assign tx_start = start_q;
    assign done     = done_q;

    ram_sw_ar #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .addr_in  (wr_q),
        .addr_out (rd_q),
        .data_in  (rx_data),
        .data_out (rd_word),
        .cs       (1'b1),
        .we       (we),
        .oe       (1'b1)
    );

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        txd_d   = txd_q;
        start_d = 1'b0;
        done_d  = done_q;
        we      = 1'b0;
        if (state_q != IDLE && !activate) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    len_d  = '0;
                    wr_d   = '0;
                    rd_d   = '0;
                    txd_d  = '0;
                    done_d = 1'b0;
                    if (activate) begin
                        state_d = GET_LEN;
                    end
                end
                GET_LEN: begin
                    if (rx_ready) begin
                        len_d = rx_data;
                        if (rx_data == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RECV;
                        end
                    end
                end
                RECV: begin
                    if (rx_ready) begin
                        we   = 1'b1;
                        wr_d = wr_q + ADDR_WIDTH'(1);
                        if (wr_last) begin
                            state_d = SEND;
                        end
                    end
                end
                SEND: begin
                    if (!tx_active) begin
                        txd_d   = rd_word;
                        start_d = 1'b1;
                        state_d = WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        rd_d = rd_q + ADDR_WIDTH'(1);
                        if (rd_last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SEND;
                        end
                    end
                end
                DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            txd_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            txd_q   <= txd_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_replay_engine.sv
// Bench for uart_replay_engine: vector table, hand sequences,
// and randomized packets checked against an echo model.
module tb_uart_replay_engine;
    import uart_replay_engine_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       activate;
    logic       done;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_active;
    logic       tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_replay_engine dut (
        .clk       (clk),
        .reset     (reset),
        .activate  (activate),
        .done      (done),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for 10 cycles, then a tx_done strobe.
    logic       busy_model = 1'b0;
    logic       force_busy = 1'b0;
    int         cnt = 0;
    int         n_start = 0;
    int         last_done_cyc = 0;
    bit         prev_done_valid = 0;
    logic [7:0] cap[$];

    assign tx_active = busy_model | force_busy;

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (reset) begin
            cnt = 0;
            busy_model = 1'b0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    busy_model = 1'b0;
                    last_done_cyc = cyc;
                    prev_done_valid = 1;
                end
            end
            if (tx_start === 1'b1) begin
                if (prev_done_valid)
                    check("turnaround", 32'(cyc - last_done_cyc), 32'd2);
                cap.push_back(tx_data);
                n_start++;
                busy_model = 1'b1;
                cnt = 10;
            end
        end
    end

    logic [7:0] ref_mem [256];
    logic [7:0] pay[$];
    logic [7:0] exp_q[$];

    task automatic drive_rx(input logic [7:0] b, input int gap);
        rx_ready = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // One full command: sends pay, expects exp_q echoed back.
    task automatic run_cmd(input string tag, input int stray,
                           input int busy);
        int t;
        int evt;
        logic [7:0] a;
        cap.delete();
        n_start = 0;
        prev_done_valid = 0;
        activate = 1'b1;
        @(negedge clk);
        evt = cyc;
        drive_rx(8'(pay.size()), 0);
        for (int i = 0; i < pay.size(); i++) begin
            if (busy > 0 && i == pay.size() - 1) force_busy = 1'b1;
            ref_mem[i] = pay[i];
            drive_rx(pay[i], int'($urandom_range(0, 2)));
        end
        if (busy > 0) begin
            repeat (busy) @(negedge clk);
            check({tag, ":busy_hold"}, 32'(n_start), 32'd0);
            force_busy = 1'b0;
            @(negedge clk);
            check({tag, ":start_after_busy"}, 32'(tx_start), 32'd1);
        end
        if (stray != 0) begin
            t = 0;
            while (n_start == 0 && t < 200) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            rx_ready = 1'b1;
            rx_data  = 8'hFF;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        t = 0;
        while (done !== 1'b1 && t < 40 * pay.size() + 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, ":done"}, 32'(done), 32'd1);
        if (pay.size() > 0)
            check({tag, ":done_lat"}, 32'(cyc - last_done_cyc), 32'd1);
        else
            check({tag, ":done_lat0"}, 32'(cyc - evt), 32'd1);
        repeat (3) @(negedge clk);
        check({tag, ":done_hold"}, 32'(done), 32'd1);
        check({tag, ":count"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            a = (i < cap.size()) ? cap[i] : 8'hxx;
            check($sformatf("%s:byte%0d", tag, i), 32'(a), 32'(exp_q[i]));
        end
        activate = 1'b0;
        @(negedge clk);
        check({tag, ":done_drop"}, 32'(done), 32'd0);
        check({tag, ":idle"}, 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
    endtask

    typedef struct {
        int             n;
        logic [2:0][7:0] d;
        int             stray;
        int             busy;
        int             ecnt;
        logic [2:0][7:0] e;
    } vec_t;

    vec_t vt [4];

    initial begin
        vt[0] = '{3, {8'h43, 8'h42, 8'h41}, 0, 0, 3, {8'h43, 8'h42, 8'h41}};
        vt[1] = '{0, {8'h00, 8'h00, 8'h00}, 0, 0, 0, {8'h00, 8'h00, 8'h00}};
        vt[2] = '{2, {8'h00, 8'h20, 8'h10}, 1, 0, 2, {8'h00, 8'h20, 8'h10}};
        vt[3] = '{2, {8'h00, 8'h55, 8'hAA}, 0, 20, 2, {8'h00, 8'h55, 8'hAA}};

        reset    = 1'b1;
        activate = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;
        @(negedge clk);
        check("rst_to_getlen", 32'(dut.state_q), 32'(GET_LEN));
        activate = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_back_idle", 32'(dut.state_q), 32'(IDLE));

        for (int k = 0; k < 4; k++) begin
            pay.delete();
            exp_q.delete();
            for (int j = 0; j < vt[k].n; j++) pay.push_back(vt[k].d[j]);
            for (int j = 0; j < vt[k].ecnt; j++) exp_q.push_back(vt[k].e[j]);
            run_cmd($sformatf("vec%0d", k), vt[k].stray, vt[k].busy);
        end

        // Abort after the first of three payload bytes.
        cap.delete();
        n_start = 0;
        activate = 1'b1;
        @(negedge clk);
        drive_rx(8'd3, 0);
        drive_rx(8'h11, 1);
        ref_mem[0] = 8'h11;
        activate = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(dut.state_q), 32'(IDLE));
        repeat (30) @(negedge clk);
        check("abort_nostart", 32'(n_start), 32'd0);

        pay.delete();
        exp_q.delete();
        pay.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        run_cmd("reactivate", 0, 0);

        // Byte strobe coincident with activate falling.
        activate = 1'b1;
        @(negedge clk);
        drive_rx(8'd2, 0);
        drive_rx(8'h77, 0);
        ref_mem[0] = 8'h77;
        rx_ready = 1'b1;
        rx_data  = 8'h99;
        activate = 1'b0;
        @(negedge clk);
        rx_ready = 1'b0;
        check("simul_idle", 32'(dut.state_q), 32'(IDLE));
        check("simul_nowrite", 32'(dut.u_ram.mem[1]), 32'(ref_mem[1]));
        @(negedge clk);

        for (int r = 0; r < 7; r++) begin
            int n;
            int st;
            int bz;
            n = (r == 2) ? 0 : (r == 6) ? 255 : int'($urandom_range(1, 24));
            st = (n > 0) ? int'($urandom_range(0, 1)) : 0;
            bz = (n > 0 && r == 5) ? int'($urandom_range(3, 8)) : 0;
            pay.delete();
            for (int j = 0; j < n; j++) pay.push_back(8'($urandom_range(0, 255)));
            exp_q = pay;
            run_cmd($sformatf("rand%0d", r), st, bz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
